freq_synth_dds: RTL and testbench
=================================

Name: freq_synth_dds

Overview:
- Programmable square-wave generator: the transmit-side counterpart of the frequency meter. It produces a test signal of a requested frequency in Hz.
- Its output drives the meter's input_clk pin for loopback measurement.
- A new frequency request arrives over a valid/ready handshake. A sequential restoring divider converts Hz to a phase-accumulator tuning word; the accumulator MSB is the output.
- Clocked by the 50 MHz board clock, same as the meter.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz; divisor for tuning-word calculation.
- ACC_W, 32: phase accumulator and tuning word width in bits.
- FREQ_W, 27: width of frequency request/report, matching the meter's 27-bit frequency value.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- freq_hz  in  FREQ_W  requested output frequency in Hz.
- freq_valid  in  1  request strobe; held with stable freq_hz until accepted.
- freq_ready  out  1  high when a request can be accepted.
- enable  in  1  run accumulator; low forces output idle.
- out_clk  out  1  generated square wave (registered accumulator MSB).
- busy  out  1  divider running (complement of freq_ready).
- tuning_word  out  ACC_W  currently applied tuning word.
- active_freq  out  FREQ_W  currently applied (clamped) frequency in Hz.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values, taking effect at the next clk edge with rst high, from any state including mid-division:
  - out_clk=0, freq_ready=1, busy=0.
  - tuning_word=0, active_freq=0, phase=0.
  - FSM=IDLE; any in-flight division is discarded.
- FSM states: IDLE, DIV, LOAD.
  - IDLE: freq_ready=1. Accept when freq_valid&&freq_ready at an edge.
  - On accept: latch f = min(freq_hz, CLK_HZ/2) (integer floor); rem=f; quo=0; counter=ACC_W-1; go to DIV.
  - DIV: freq_ready=0, busy=1. Each cycle: r2=2*rem. If r2>=CLK_HZ then rem=r2-CLK_HZ and shift in 1; else rem=r2 and shift in 0. After ACC_W cycles go to LOAD.
  - LOAD: tuning_word<=quo, active_freq<=f; next state IDLE.
- Result: tuning_word = floor(f*2^ACC_W/CLK_HZ), exact.
  - Remainder register width: clog2(CLK_HZ)+1 bits.
  - f <= CLK_HZ/2 guarantees the quotient fits in ACC_W bits.
- Latency: accept edge = cycle 0; tuning_word and active_freq update at edge ACC_W+1; freq_ready high again from edge ACC_W+1 onward.
- Back-to-back requests: a new request is acceptable at edge ACC_W+2 at the earliest.
- freq_valid while busy: not accepted; no effect.
- Accumulator:
  - enable=1: phase<=phase+tuning_word each cycle, mod 2^ACC_W; out_clk<=phase[ACC_W-1] (one-cycle registered).
  - enable=0: phase<=0 and out_clk<=0.
- Tuning-word change is phase-continuous: the accumulator is not cleared on LOAD.
- freq_hz=0 gives tuning_word=0, so out_clk holds its current value. It is 0 after reset or enable-low.
- freq_hz>=CLK_HZ/2 clamps: tuning_word=2^(ACC_W-1), so out_clk toggles every cycle; active_freq=CLK_HZ/2.
- The division FSM runs regardless of enable.

Optional Feature:
- Macro: FREQ_SYNTH_EDGE_COUNT_EN.
- When defined:
  - Adds output edge_count [FREQ_W-1:0] and output edge_count_valid [1].
  - A gate counter runs CLK_HZ clk cycles (1 s at 50 MHz).
  - Internal rising edges of out_clk are counted.
  - At gate end: edge_count<=count, edge_count_valid pulses high for one cycle, counter restarts at 0.
  - The edge that falls on the gate-end cycle is counted in the new window.
  - Reset clears edge_count, edge_count_valid, the gate counter and the edge counter.
- When not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with defaults -> out_clk=0, freq_ready=1, tuning_word=0, active_freq=0; these hold while rst=1 even with freq_valid=1.
- Defaults, freq_hz=1000 accepted at cycle 0 -> freq_ready=0 on cycles 1..32; tuning_word=85899, active_freq=1000 and freq_ready=1 from edge 33.
- Defaults, freq_hz=30000000 -> clamped: active_freq=25000000, tuning_word=2147483648; out_clk toggles every clk cycle with enable=1.
- Request 1 Hz, then assert rst at DIV cycle 10 -> FSM idle, tuning_word stays 0, freq_ready=1 the cycle after rst; a new request of 1 Hz then gives tuning_word=85.
- CLK_HZ=1000, ACC_W=16, freq_hz=100, enable=1 -> out_clk period is 10 cycles on average (tuning_word=6553); drop enable -> out_clk=0 next edge, phase reset.
- FREQ_SYNTH_EDGE_COUNT_EN defined, CLK_HZ=1000, ACC_W=16, freq_hz=100 -> edge_count in {99,100} on each edge_count_valid pulse, pulses exactly 1000 cycles apart.

Source files
------------

// File: rtl/freq_synth_dds.sv
// Programmable square-wave generator: Hz request -> restoring divider -> phase-accumulator tuning word.
// Optional FREQ_SYNTH_EDGE_COUNT_EN adds a 1-gate self-measurement of out_clk rising edges.
module freq_synth_dds #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned FREQ_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] freq_hz,
    input  logic              freq_valid,
    output logic              freq_ready,
    input  logic              enable,
    output logic              out_clk,
    output logic              busy,
    output logic [ACC_W-1:0]  tuning_word,
    output logic [FREQ_W-1:0] active_freq
`ifdef FREQ_SYNTH_EDGE_COUNT_EN
    ,
    output logic [FREQ_W-1:0] edge_count,
    output logic              edge_count_valid
`endif
);

    localparam int unsigned REM_W = $clog2(CLK_HZ) + 1;
    localparam int unsigned CNT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam logic [REM_W:0]    CLK_X  = (REM_W + 1)'(CLK_HZ);
    localparam logic [FREQ_W-1:0] HALF_F = FREQ_W'(CLK_HZ / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_LOAD
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_ready;

    logic [REM_W-1:0]    r_rem;
    logic [ACC_W-1:0]    r_quo;
    logic [CNT_W-1:0]    r_cnt;
    logic [FREQ_W-1:0]   r_f;
    logic [ACC_W-1:0]    r_tw;
    logic [FREQ_W-1:0]   r_af;
    logic [ACC_W-1:0]    r_phase;
    logic                r_out_clk;

    logic                w_over;
    logic [FREQ_W-1:0]   w_f_clamped;
    logic [REM_W:0]      w_rem2;
    logic                w_ge;
    logic                w_out_next;

    // Requests above Nyquist are pinned to CLK_HZ/2 so the quotient always fits ACC_W bits.
    assign w_over      = (64'(freq_hz) > 64'(CLK_HZ / 2));
    assign w_f_clamped = w_over ? HALF_F : freq_hz;

    assign w_rem2 = {r_rem, 1'b0};
    assign w_ge   = (w_rem2 >= CLK_X);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (freq_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == '0) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_f   <= '0;
            r_tw  <= '0;
            r_af  <= '0;
        end else if (w_accept) begin
            r_f   <= w_f_clamped;
            r_rem <= REM_W'(w_f_clamped);
            r_quo <= '0;
            r_cnt <= CNT_W'(ACC_W - 1);
        end else if (r_state == S_DIV) begin
            r_rem <= w_ge ? REM_W'(w_rem2 - CLK_X) : REM_W'(w_rem2);
            r_quo <= {r_quo[ACC_W-2:0], w_ge};
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (r_state == S_LOAD) begin
            r_tw <= r_quo;
            r_af <= r_f;
        end
    end

    // Phase keeps running across tuning-word changes; only reset or enable-low clears it.
    assign w_out_next = enable & r_phase[ACC_W-1];

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_phase   <= '0;
            r_out_clk <= 1'b0;
        end else begin
            r_phase   <= r_phase + r_tw;
            r_out_clk <= w_out_next;
        end
    end

    assign freq_ready  = w_ready;
    assign busy        = ~w_ready;
    assign out_clk     = r_out_clk;
    assign tuning_word = r_tw;
    assign active_freq = r_af;

`ifdef FREQ_SYNTH_EDGE_COUNT_EN
    localparam int unsigned GATE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [GATE_W-1:0] r_gate;
    logic [FREQ_W-1:0] r_edges;
    logic [FREQ_W-1:0] r_ec;
    logic              r_ecv;
    logic              w_rise;
    logic              w_gate_end;

    assign w_rise     = w_out_next & ~r_out_clk;
    assign w_gate_end = (r_gate == GATE_W'(CLK_HZ - 1));

    // A rise on the gate-end cycle opens the next window rather than closing this one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate  <= '0;
            r_edges <= '0;
            r_ec    <= '0;
            r_ecv   <= 1'b0;
        end else begin
            r_ecv <= w_gate_end;
            if (w_gate_end) begin
                r_gate  <= '0;
                r_ec    <= r_edges;
                r_edges <= FREQ_W'(w_rise);
            end else begin
                r_gate  <= r_gate + GATE_W'(1);
                r_edges <= r_edges + FREQ_W'(w_rise);
            end
        end
    end

    assign edge_count       = r_ec;
    assign edge_count_valid = r_ecv;
`endif

endmodule

// File: tb/tb_freq_synth_dds.sv
// Randomized bench for freq_synth_dds: a full-size and a small (CLK_HZ=1000, ACC_W=16) instance,
// each compared every cycle against an arithmetic model of the request/accumulator rules.
module tb_freq_synth_dds;

    localparam int unsigned FW = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          enable;
    logic [FW-1:0] freq_a, freq_b;
    logic          valid_a, valid_b;
    logic          ready_a, ready_b, busy_a, busy_b, out_a, out_b;
    logic [31:0]   tw_a;
    logic [15:0]   tw_b;
    logic [FW-1:0] af_a, af_b;
`ifdef FREQ_SYNTH_EDGE_COUNT_EN
    logic [FW-1:0] ec_a, ec_b;
    logic          ecv_a, ecv_b;
`endif

    freq_synth_dds u_dut_a (
        .clk(clk), .rst(rst), .freq_hz(freq_a), .freq_valid(valid_a), .freq_ready(ready_a),
        .enable(enable), .out_clk(out_a), .busy(busy_a), .tuning_word(tw_a), .active_freq(af_a)
`ifdef FREQ_SYNTH_EDGE_COUNT_EN
        , .edge_count(ec_a), .edge_count_valid(ecv_a)
`endif
    );

    freq_synth_dds #(.CLK_HZ(1000), .ACC_W(16), .FREQ_W(FW)) u_dut_b (
        .clk(clk), .rst(rst), .freq_hz(freq_b), .freq_valid(valid_b), .freq_ready(ready_b),
        .enable(enable), .out_clk(out_b), .busy(busy_b), .tuning_word(tw_b), .active_freq(af_b)
`ifdef FREQ_SYNTH_EDGE_COUNT_EN
        , .edge_count(ec_b), .edge_count_valid(ecv_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one entry per instance.
    longint unsigned m_clk[2]   = '{64'd50000000, 64'd1000};
    int              m_acc_w[2] = '{32, 16};
    longint unsigned m_phase[2], m_tw[2], m_af[2], m_f[2];
    longint unsigned m_gate[2], m_edges[2], m_ec[2];
    int              m_wait[2];
    bit              m_out[2], m_took[2], m_ecv[2];

    function automatic longint unsigned clamp_f(int k, longint unsigned f);
        return (f > m_clk[k] / 2) ? m_clk[k] / 2 : f;
    endfunction

    function automatic longint unsigned tw_of(int k, longint unsigned f);
        return (f << m_acc_w[k]) / m_clk[k];
    endfunction

    task automatic model_step(input int k, input bit v, input longint unsigned fq);
        longint unsigned mask;
        bit nout, rise;
        m_took[k] = 0;
        rise = 0;
        if (rst) begin
            m_phase[k] = 0; m_tw[k] = 0; m_af[k] = 0; m_wait[k] = 0; m_out[k] = 0;
            m_gate[k] = 0; m_edges[k] = 0; m_ec[k] = 0; m_ecv[k] = 0;
        end else begin
            mask = (64'd1 << m_acc_w[k]) - 1;
            nout = enable ? bit'((m_phase[k] >> (m_acc_w[k] - 1)) & 1) : 1'b0;
            rise = nout && !m_out[k];
            m_phase[k] = enable ? ((m_phase[k] + m_tw[k]) & mask) : 0;
            m_out[k] = nout;
            if (m_wait[k] == 0) begin
                if (v) begin
                    m_f[k] = clamp_f(k, fq);
                    m_wait[k] = m_acc_w[k] + 1;
                    m_took[k] = 1;
                end
            end else begin
                m_wait[k]--;
                if (m_wait[k] == 0) begin
                    m_tw[k] = tw_of(k, m_f[k]);
                    m_af[k] = m_f[k];
                end
            end
            m_ecv[k] = (m_gate[k] == m_clk[k] - 1);
            if (m_ecv[k]) begin
                m_ec[k] = m_edges[k];
                m_edges[k] = rise;
                m_gate[k] = 0;
            end else begin
                m_gate[k]++;
                m_edges[k] += rise;
            end
        end
    endtask

    task automatic compare_all();
        check("ready_a", ready_a, m_wait[0] == 0);
        check("busy_a", busy_a, m_wait[0] != 0);
        check("tw_a", tw_a, m_tw[0]);
        check("af_a", af_a, m_af[0]);
        check("out_a", out_a, m_out[0]);
        check("ready_b", ready_b, m_wait[1] == 0);
        check("busy_b", busy_b, m_wait[1] != 0);
        check("tw_b", tw_b, m_tw[1]);
        check("af_b", af_b, m_af[1]);
        check("out_b", out_b, m_out[1]);
`ifdef FREQ_SYNTH_EDGE_COUNT_EN
        check("ec_a", ec_a, m_ec[0]);
        check("ecv_a", ecv_a, m_ecv[0]);
        check("ec_b", ec_b, m_ec[1]);
        check("ecv_b", ecv_b, m_ecv[1]);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, valid_a, freq_a);
        model_step(1, valid_b, freq_b);
        #1;
        compare_all();
        if (m_took[0]) valid_a = 1'b0;
        if (m_took[1]) valid_b = 1'b0;
    endtask

    task automatic run_req(input int k, input logic [FW-1:0] f);
        int g;
        if (k == 0) begin freq_a = f; valid_a = 1'b1; end
        else        begin freq_b = f; valid_b = 1'b1; end
        tick();
        g = 0;
        while (((k == 0) ? ready_a : ready_b) !== 1'b1 && g < 200) begin
            tick();
            g++;
        end
        check("req_done_in_time", g < 200, 1);
    endtask

    function automatic logic [FW-1:0] pick_freq(int k);
        longint unsigned half;
        half = m_clk[k] / 2;
        case ($urandom_range(5))
            0:       return '0;
            1:       return FW'(half);
            2:       return FW'(half + 1);
            3:       return FW'($urandom_range(int'(m_clk[k])));
            4:       return FW'($urandom);
            default: return FW'($urandom_range(1, 50));
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_low, g, rises, last_pulse, n_pulse;
        bit  prev;

        rst = 1'b1; enable = 1'b0;
        valid_a = 1'b1; freq_a = FW'(1000);
        valid_b = 1'b0; freq_b = '0;
        repeat (3) tick();
        check("rst_hold_ready", ready_a, 1);
        check("rst_hold_tw", tw_a, 0);
        check("rst_hold_out", out_a, 0);

        // 1 kHz request: ready low from the accept sample through edge ACC_W.
        rst = 1'b0;
        tick();
        n_low = 0; g = 0;
        while (ready_a !== 1'b1 && g < 100) begin
            n_low++;
            tick();
            g++;
        end
        check("lat_ready_low", n_low, 33);
        check("lat_tw_1k", tw_a, 85899);
        check("lat_af_1k", af_a, 1000);

        // Clamp above Nyquist: out_clk must toggle every cycle.
        enable = 1'b1;
        run_req(0, FW'(30000000));
        check("clamp_af", af_a, 25000000);
        check("clamp_tw", tw_a, 64'd2147483648);
        repeat (2) tick();
        prev = out_a;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("clamp_toggle", out_a, !prev);
            prev = out_a;
        end

        // Reset in the middle of a division.
        enable = 1'b0;
        freq_a = FW'(1); valid_a = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_div_rst_ready", ready_a, 1);
        check("mid_div_rst_tw", tw_a, 0);
        run_req(0, FW'(1));
        check("one_hz_tw", tw_a, 85);

        // Small instance: 100 Hz at 1 kHz clock, ~10-cycle period.
        run_req(1, FW'(100));
        check("small_tw", tw_b, 6553);
        enable = 1'b1;
        rises = 0; last_pulse = -1; n_pulse = 0;
        for (int i = 0; i < 2100; i++) begin
            prev = out_b;
            tick();
            if (i < 1000 && out_b && !prev) rises++;
`ifdef FREQ_SYNTH_EDGE_COUNT_EN
            if (ecv_b) begin
                n_pulse++;
                if (last_pulse >= 0) check("gate_spacing", i - last_pulse, 1000);
                if (n_pulse >= 2) check("gate_count_range", (ec_b >= 99) && (ec_b <= 100), 1);
                last_pulse = i;
            end
`endif
        end
        check("small_rises", (rises >= 99) && (rises <= 100), 1);
`ifdef FREQ_SYNTH_EDGE_COUNT_EN
        check("gate_pulses", n_pulse >= 2, 1);
`endif
        enable = 1'b0;
        tick();
        check("disable_out_b", out_b, 0);
        check("disable_out_a", out_a, 0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) enable = ~enable;
            rst = ($urandom_range(599) == 0);
            if (!valid_a && $urandom_range(15) == 0) begin freq_a = pick_freq(0); valid_a = 1'b1; end
            if (!valid_b && $urandom_range(15) == 0) begin freq_b = pick_freq(1); valid_b = 1'b1; end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
